// File: rtl/gpio_bank_arbiter.sv
// gpio_bank_arbiter: shares one WIDTH-pad GPIO bank between NREQ requesters.
// Round-robin ownership with a bounded lease while others wait, and a forced
// turnaround window with released pads between consecutive owners so two
// owners can never drive the pads in the same cycle.

module gpio_bank_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned LEASE_CYCLES = 8,
  parameter int unsigned TURN_CYCLES  = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_out,
  input  logic [NREQ*WIDTH-1:0]   req_oeb,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        io_out,
  output logic [WIDTH-1:0]        io_oeb,
  output logic                    busy,
  output logic                    lease_expired
);

  localparam int unsigned PtrW     = $clog2(NREQ);
  localparam logic [7:0]  LeaseMax = 8'(LEASE_CYCLES);
  localparam logic [3:0]  TurnLen  = 4'(TURN_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [7:0]        lease_q, lease_d;
  logic [3:0]        turn_q, turn_d;
  logic [WIDTH-1:0]  io_out_q, io_out_d;
  logic [WIDTH-1:0]  io_oeb_q, io_oeb_d;
  logic              lease_exp_q, lease_exp_d;

  logic              pick_valid;
  logic [PtrW-1:0]   pick_idx;
  logic [PtrW-1:0]   cand;
  logic [WIDTH-1:0]  owner_out;
  logic [WIDTH-1:0]  owner_oeb;
  logic              owner_req;
  logic              others_pending;
  logic [PtrW-1:0]   ptr_after_owner;
  logic              lease_at_max;

  // Round-robin pick: first requester found scanning ptr, ptr+1, ... mod NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Select the current owner's pad data and output-enable-bar.
  always_comb begin
    owner_out = '0;
    owner_oeb = '1;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (owner_q == PtrW'(k)) begin
        owner_out = req_out[k*WIDTH +: WIDTH];
        owner_oeb = req_oeb[k*WIDTH +: WIDTH];
      end
    end
  end

  // Owner status and the pointer value used after the owner leaves.
  always_comb begin
    owner_req       = req[owner_q];
    // gnt_q is the owner's one-hot while in StGrant, so masking leaves the others.
    others_pending  = |(req & ~gnt_q);
    lease_at_max    = (lease_q == LeaseMax);
    ptr_after_owner = (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + PtrW'(1);
  end

  // Next-state and registered-output logic for the ownership FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    lease_d     = lease_q;
    turn_d      = turn_q;
    io_out_d    = '0;
    io_oeb_d    = '1;
    lease_exp_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          owner_d = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          lease_d = 8'd1;
        end
      end

      StGrant: begin
        // Pads follow the owner's inputs with one cycle of lag, including on
        // the exit edge, so data persists one cycle after gnt falls.
        io_out_d = owner_out;
        io_oeb_d = owner_oeb;
        if (!owner_req || (lease_at_max && others_pending)) begin
          state_d     = StTurn;
          gnt_d       = '0;
          ptr_d       = ptr_after_owner;
          turn_d      = TurnLen;
          lease_d     = '0;
          lease_exp_d = owner_req;
        end else if (lease_at_max) begin
          lease_d = 8'd1;
        end else begin
          lease_d = lease_q + 8'd1;
        end
      end

      StTurn: begin
        // Requests are ignored here; pads stay released.
        turn_d = turn_q - 4'd1;
        if (turn_q <= 4'd1) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset releases the pads at once.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      lease_q     <= '0;
      turn_q      <= '0;
      io_out_q    <= '0;
      io_oeb_q    <= '1;
      lease_exp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      lease_q     <= lease_d;
      turn_q      <= turn_d;
      io_out_q    <= io_out_d;
      io_oeb_q    <= io_oeb_d;
      lease_exp_q <= lease_exp_d;
    end
  end

  assign gnt           = gnt_q;
  assign io_out        = io_out_q;
  assign io_oeb        = io_oeb_q;
  assign busy          = (state_q != StIdle);
  assign lease_expired = lease_exp_q;

`ifndef SYNTHESIS
  gnt_onehot0_a: assert property (@(posedge wb_clk_i) $onehot0(gnt_q));
  idle_released_a: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
                                    (state_q == StIdle) |-> (&io_oeb_q));
`endif

endmodule

// File: tb/tb_gpio_bank_arbiter.sv
// Bench for gpio_bank_arbiter: directed scenarios with literal expectations,
// plus a cycle-level behavioural model compared against the DUT every cycle.

module tb_gpio_bank_arbiter;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int LEASE = 8;
  localparam int TURN  = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_out;
  logic [N*W-1:0]   req_oeb;
  logic [N-1:0]     gnt;
  logic [W-1:0]     io_out;
  logic [W-1:0]     io_oeb;
  logic             busy;
  logic             lease_expired;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_bank_arbiter #(
    .NREQ         (N),
    .WIDTH        (W),
    .LEASE_CYCLES (LEASE),
    .TURN_CYCLES  (TURN)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .req           (req),
    .req_out       (req_out),
    .req_oeb       (req_oeb),
    .gnt           (gnt),
    .io_out        (io_out),
    .io_oeb        (io_oeb),
    .busy          (busy),
    .lease_expired (lease_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_data(input int k, input logic [W-1:0] d, input logic [W-1:0] oeb);
    req_out[k*W +: W] = d;
    req_oeb[k*W +: W] = oeb;
  endtask

  // Behavioural model: who owns the bank, how long, and how much release
  // time remains before a new owner may be chosen.
  int           m_owner;
  int           m_ptr;
  int           m_lease;
  int           m_turn;
  logic [W-1:0] m_out;
  logic [W-1:0] m_oeb;
  logic         m_le;
  bit           m_valid = 1'b0;
  logic [N-1:0] own_oh;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_lease = 0;
      m_turn  = 0;
      m_out   = '0;
      m_oeb   = '1;
      m_le    = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_le = 1'b0;
      if (m_owner >= 0) begin
        own_oh = 4'b0001 << m_owner;
        m_out  = req_out[m_owner*W +: W];
        m_oeb  = req_oeb[m_owner*W +: W];
        if ((req & own_oh) == 0) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_turn  = TURN;
        end else if (m_lease == LEASE && (req & ~own_oh) != 0) begin
          m_le    = 1'b1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_turn  = TURN;
        end else if (m_lease == LEASE) begin
          m_lease = 1;
        end else begin
          m_lease = m_lease + 1;
        end
      end else begin
        m_out = '0;
        m_oeb = '1;
        if (m_turn > 0) begin
          m_turn = m_turn - 1;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (m_owner < 0 && req[(m_ptr + i) % N]) begin
              m_owner = (m_ptr + i) % N;
              m_lease = 1;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  logic [N-1:0] exp_gnt;
  always @(negedge clk) begin
    if (m_valid) begin
      exp_gnt = '0;
      if (m_owner >= 0) exp_gnt = 4'b0001 << m_owner;
      check("model_gnt", 64'(gnt), 64'(exp_gnt));
      check("model_io_out", 64'(io_out), 64'(m_out));
      check("model_io_oeb", 64'(io_oeb), 64'(m_oeb));
      check("model_busy", 64'(busy), 64'((m_owner >= 0) || (m_turn > 0)));
      check("model_lease_expired", 64'(lease_expired), 64'(m_le));
      check("gnt_onehot0", 64'($onehot0(gnt)), 64'(1));
    end
  end

  // Record grant-rise order and lease-expiry pulses observed on the DUT.
  int           order_q[$];
  int           pulse_cnt = 0;
  logic [N-1:0] prev_gnt  = '0;
  always @(negedge clk) begin
    if (gnt != 0 && prev_gnt == 0) begin
      for (int k = 0; k < N; k++) begin
        if (gnt[k]) order_q.push_back(k);
      end
    end
    if (lease_expired === 1'b1) pulse_cnt++;
    prev_gnt = gnt;
  end

  int q0;
  int p0;

  initial begin
    rst     = 1'b1;
    req     = '0;
    req_out = '0;
    req_oeb = '1;

    // Reset then idle.
    step(2);
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_io_oeb", 64'(io_oeb), 64'hFFFF);
    check("rst_io_out", 64'(io_out), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    step(10);
    check("idle_gnt", 64'(gnt), 64'h0);
    check("idle_busy", 64'(busy), 64'h0);

    // Single requester.
    set_data(1, 16'hA5A5, 16'h0000);
    req = 4'b0010;
    step(1);
    check("single_gnt", 64'(gnt), 64'b0010);
    check("single_pad_lag", 64'(io_oeb), 64'hFFFF);
    step(1);
    check("single_io_out", 64'(io_out), 64'hA5A5);
    check("single_io_oeb", 64'(io_oeb), 64'h0000);
    check("single_busy", 64'(busy), 64'h1);
    set_data(1, 16'h5A5A, 16'h0000);
    step(1);
    check("single_data_follow", 64'(io_out), 64'h5A5A);
    step(12);
    req = 4'b0000;
    step(1);
    check("drop_gnt", 64'(gnt), 64'h0);
    check("drop_data_persist", 64'(io_out), 64'h5A5A);
    step(1);
    check("turn_io_oeb", 64'(io_oeb), 64'hFFFF);
    check("turn_io_out", 64'(io_out), 64'h0);
    check("turn_busy", 64'(busy), 64'h1);
    step(1);
    check("turn_done_busy", 64'(busy), 64'h0);

    // Simultaneous requests from a fresh pointer.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      set_data(k, 16'(16'h1111 * (k + 1)), 16'(16'h00F0 >> k));
    end
    q0  = order_q.size();
    p0  = pulse_cnt;
    req = 4'b1111;
    step(1);
    check("all_first_gnt", 64'(gnt), 64'b0001);
    step(7);
    check("all_lease_last", 64'(gnt), 64'b0001);
    step(1);
    check("all_expire_gnt", 64'(gnt), 64'h0);
    check("all_expire_pulse", 64'(lease_expired), 64'h1);
    step(1);
    check("all_pulse_one_cycle", 64'(lease_expired), 64'h0);
    step(2);
    check("all_second_gnt", 64'(gnt), 64'b0010);
    step(33);
    check("all_fifth_gnt", 64'(gnt), 64'b0001);
    step(2);
    req = 4'b0000;
    step(4);
    check("all_order_count", 64'(order_q.size() - q0), 64'd5);
    if (order_q.size() - q0 == 5) begin
      check("all_order_0", 64'(order_q[q0 + 0]), 64'd0);
      check("all_order_1", 64'(order_q[q0 + 1]), 64'd1);
      check("all_order_2", 64'(order_q[q0 + 2]), 64'd2);
      check("all_order_3", 64'(order_q[q0 + 3]), 64'd3);
      check("all_order_4", 64'(order_q[q0 + 4]), 64'd0);
    end
    check("all_pulse_count", 64'(pulse_cnt - p0), 64'd4);

    // Lease renewal with a lone requester.
    p0  = pulse_cnt;
    req = 4'b0100;
    step(1);
    for (int i = 0; i < 40; i++) begin
      check("renew_gnt", 64'(gnt), 64'b0100);
      step(1);
    end
    check("renew_no_pulse", 64'(pulse_cnt - p0), 64'd0);
    req = 4'b0000;
    step(4);

    // Pointer wrap-around: serve 3, then 0 with 3 pending, then back to 3.
    req = 4'b1000;
    step(1);
    check("wrap_first3", 64'(gnt), 64'b1000);
    step(2);
    req = 4'b0001;
    step(1);
    check("wrap_release3", 64'(gnt), 64'h0);
    req = 4'b1001;
    step(3);
    check("wrap_to0", 64'(gnt), 64'b0001);
    step(11);
    check("wrap_back3", 64'(gnt), 64'b1000);
    req = 4'b0000;
    step(4);

    // Reset while requester 1 owns the bank.
    set_data(1, 16'h1234, 16'h0000);
    req = 4'b0010;
    step(1);
    check("midrst_gnt", 64'(gnt), 64'b0010);
    step(2);
    check("midrst_io_out", 64'(io_out), 64'h1234);
    rst = 1'b1;
    req = 4'b0011;
    step(1);
    check("midrst_after_gnt", 64'(gnt), 64'h0);
    check("midrst_after_oeb", 64'(io_oeb), 64'hFFFF);
    check("midrst_after_out", 64'(io_out), 64'h0);
    check("midrst_after_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    step(1);
    check("post_rst_grant", 64'(gnt), 64'b0001);
    step(3);
    req = 4'b0000;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_bank_arbiter.md
Name: gpio_bank_arbiter

Overview:
- Shares one 16-pad bank of user-project GPIO (mprj_io[31:16] via io_out/io_oeb) between NREQ on-chip requesters.
- Uses round-robin arbitration with a bounded lease and forced bus-turnaround, so two owners never drive the pads in the same cycle.
- Sits in the user project, between requester logic and the io_out/io_oeb bank.
- Pads are released (io_oeb all 1) whenever no owner holds the bank, so an external agent can drive them.

Parameters:
- NREQ, 4: number of requesters, range 2..8.
- WIDTH, 16: pad bank width.
- LEASE_CYCLES, 8: maximum consecutive grant cycles while another request is pending, range 1..255.
- TURN_CYCLES, 2: released-pad cycles between owners, range 1..15.

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- req  in  NREQ  level request, one bit per requester.
- req_out  in  NREQ*WIDTH  requester k output data at bits [k*WIDTH +: WIDTH].
- req_oeb  in  NREQ*WIDTH  requester k output-enable-bar, same packing.
- gnt  out  NREQ  one-hot grant; all-zero when no owner.
- io_out  out  WIDTH  registered pad data.
- io_oeb  out  WIDTH  registered pad output-enable-bar (1 = input/released).
- busy  out  1  high when state != IDLE.
- lease_expired  out  1  one-cycle pulse when a grant is revoked by lease expiry.

Behaviour:
- Reset (wb_rst_i sampled high at an edge):
  - state=IDLE, gnt=0, io_out=0, io_oeb=all 1, busy=0, lease_expired=0, rr pointer ptr=0, lease counter=0.
  - Reset overrides everything, including mid-GRANT or mid-TURN. Pads are released on the same edge.
- States:
  - IDLE: if any req bit is high, pick the first set bit scanning ptr, ptr+1, … modulo NREQ. Set gnt one-hot to that owner and counter=1, then go to GRANT. Latency: req sampled high at edge N gives gnt high after edge N. With no req, stay in IDLE.
  - GRANT:
    - Every edge: io_out <= req_out[owner], io_oeb <= req_oeb[owner]. Pads therefore lag the requester inputs by exactly one cycle.
    - If req[owner] is sampled low: gnt<=0, ptr<=(owner+1) mod NREQ, turn counter=TURN_CYCLES, go to TURN.
    - Else if counter==LEASE_CYCLES and any other req bit is high: same exit as above, plus lease_expired=1 for one cycle.
    - Else if counter==LEASE_CYCLES with no other request: counter<=1 (lease renewed; the owner stays).
    - Else counter<=counter+1.
  - TURN:
    - io_out<=0 and io_oeb<=all 1 on the first TURN edge. This means the owner's data persists exactly one cycle after gnt falls.
    - Decrement the turn counter each edge. At 1, go to IDLE.
    - Requests are ignored during TURN.
- In IDLE and TURN, io_out=0 and io_oeb=all 1.
- Minimum gap between gnt falling and the next gnt rising is TURN_CYCLES+1 cycles (TURN plus the IDLE decision cycle).
- Width rules:
  - Lease counter is 8 bit and turn counter is 4 bit.
  - Pointer wraps from NREQ-1 to 0.
- Exactly zero or one gnt bit is high in every cycle.
- A requester that drops req and reasserts it during TURN waits its round-robin turn. It has no priority from its previous ownership.

Test Plan:
- Reset then idle: hold wb_rst_i 2 cycles, req=0 for 10 cycles -> gnt=0000, io_oeb=16'hFFFF, io_out=0, busy=0 throughout.
- Single requester: req=0010 from cycle 5, req_out[1]=16'hA5A5, req_oeb[1]=0 -> gnt=0010 after edge 5, io_out=A5A5 and io_oeb=0000 one edge later. Drop req at cycle 20 -> gnt=0 next edge, io_oeb=FFFF one edge after that, busy low after 2 TURN cycles.
- Simultaneous requests: req=1111 held, defaults -> grant order 0,1,2,3,0; each held 8 cycles; lease_expired pulses once per handoff; 3-cycle gnt gap between owners; never two gnt bits set.
- Lease renewal: only req[2] high for 40 cycles -> gnt=0100 continuously, no lease_expired, counter renews at 8.
- Wrap-around: ptr at 3 after serving req3 with req=1001 pending -> next grant to requester 0, then to requester 3.
- Reset mid-GRANT: assert wb_rst_i while requester 1 owns the bank driving 16'h1234 -> after that edge gnt=0, io_oeb=FFFF, io_out=0. After release with req=0011, first grant goes to requester 0 (ptr=0).
